// File: rtl/xa_bf_pkg.sv
// Shared types and constants for the BF output framer.
// The XA_BF_OUT_HDR_EN macro adds the header state and helper.
package xa_bf_pkg;

  localparam int DATA_W = 32;
  localparam int FT_W   = 5;
  localparam int PAD_W  = 20;
  localparam int CNT_W  = 16;

  localparam logic [7:0] HDR_SYNC = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
`ifdef XA_BF_OUT_HDR_EN
    S_HDR  = 3'd1,
`endif
    S_DATA = 3'd2,
    S_PAD  = 3'd3,
    S_END  = 3'd4,
    S_DONE = 3'd5
  } state_t;

`ifdef XA_BF_OUT_HDR_EN
  function automatic logic [DATA_W-1:0] hdr_word(input logic [FT_W-1:0] ft,
                                                 input logic [CNT_W-1:0] n);
    return {HDR_SYNC, 3'b000, ft, n};
  endfunction
`endif

endpackage

// File: rtl/xa_bf_out_frm_if.sv
// Valid/ready stream bundle used for both the input and output sides of the framer.
interface xa_bf_out_frm_if;
  import xa_bf_pkg::*;

  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/xa_bf_beat_cnt.sv
// Loadable saturating down-counter; term is high while the count sits at zero,
// which marks the beat currently offered as the final one of its phase.
module xa_bf_beat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         term
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term = (cnt_q == '0);

endmodule

// File: rtl/xa_bf_out_frm.sv
// Frames BF calculation results: [header] + data + [padding] + [end code].
// Header word is built only when XA_BF_OUT_HDR_EN is defined.
module xa_bf_out_frm
  import xa_bf_pkg::*;
#(
  parameter logic [15:0] P_data_num = 16'd1024,
  parameter logic [31:0] P_pad_data = 32'h0000_0000,
  parameter logic [31:0] P_end_code = 32'hFFFF_FFFF
) (
  input  logic             i_clk156m,
  input  logic             i_srst,
  input  logic             i_calc_start,
  input  logic [FT_W-1:0]  i_frame_time,
  input  logic [PAD_W-1:0] i_pad_size,
  input  logic             i_end_ins,
  xa_bf_out_frm_if.slave   din_if,
  xa_bf_out_frm_if.master  dout_if,
  output logic             o_sp_end,
  output logic             o_busy,
  output logic             o_err_ovl
);

  state_t state_q, state_d;
  logic   pad_nz_q, pad_nz_d;
  logic   end_ins_q, end_ins_d;
  logic   err_ovl_q, err_ovl_d;
  logic   cnt_load, data_dec, pad_dec;
  logic   data_term, pad_term;

`ifdef XA_BF_OUT_HDR_EN
  logic [FT_W-1:0] ft_q, ft_d;
  logic            hdr_first_q, hdr_first_d;
  logic [FT_W-1:0] ft_cur;
`else
  logic unused_frame_time;
  assign unused_frame_time = ^i_frame_time;
`endif

  xa_bf_beat_cnt #(.W(CNT_W)) u_data_cnt (
    .clk      (i_clk156m),
    .srst     (i_srst),
    .load     (cnt_load),
    .load_val (P_data_num - 16'd1),
    .dec      (data_dec),
    .term     (data_term)
  );

  xa_bf_beat_cnt #(.W(PAD_W)) u_pad_cnt (
    .clk      (i_clk156m),
    .srst     (i_srst),
    .load     (cnt_load),
    .load_val ((i_pad_size != '0) ? (i_pad_size - 20'd1) : '0),
    .dec      (pad_dec),
    .term     (pad_term)
  );

  always_comb begin
    state_d       = state_q;
    pad_nz_d      = pad_nz_q;
    end_ins_d     = end_ins_q;
    err_ovl_d     = err_ovl_q | (i_calc_start && (state_q != S_IDLE));
    cnt_load      = 1'b0;
    data_dec      = 1'b0;
    pad_dec       = 1'b0;
    dout_if.data  = '0;
    dout_if.valid = 1'b0;
    dout_if.last  = 1'b0;
    din_if.ready  = 1'b0;
`ifdef XA_BF_OUT_HDR_EN
    ft_d          = ft_q;
    hdr_first_d   = hdr_first_q;
    // frame_time only becomes valid in the first header cycle, so it is used live once then held
    ft_cur        = hdr_first_q ? i_frame_time : ft_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (i_calc_start) begin
          pad_nz_d  = (i_pad_size != '0);
          end_ins_d = i_end_ins;
          cnt_load  = 1'b1;
`ifdef XA_BF_OUT_HDR_EN
          hdr_first_d = 1'b1;
          state_d     = S_HDR;
`else
          state_d     = S_DATA;
`endif
        end
      end
`ifdef XA_BF_OUT_HDR_EN
      S_HDR: begin
        dout_if.data  = hdr_word(ft_cur, P_data_num);
        dout_if.valid = 1'b1;
        ft_d          = ft_cur;
        hdr_first_d   = 1'b0;
        if (dout_if.ready) begin
          state_d = S_DATA;
        end
      end
`endif
      S_DATA: begin
        dout_if.data  = din_if.data;
        dout_if.valid = din_if.valid;
        din_if.ready  = dout_if.ready;
        dout_if.last  = din_if.valid && data_term && !pad_nz_q && !end_ins_q;
        if (din_if.valid && dout_if.ready) begin
          data_dec = 1'b1;
          if (data_term) begin
            state_d = pad_nz_q ? S_PAD : (end_ins_q ? S_END : S_DONE);
          end
        end
      end
      S_PAD: begin
        dout_if.data  = P_pad_data;
        dout_if.valid = 1'b1;
        dout_if.last  = pad_term && !end_ins_q;
        if (dout_if.ready) begin
          pad_dec = 1'b1;
          if (pad_term) begin
            state_d = end_ins_q ? S_END : S_DONE;
          end
        end
      end
      S_END: begin
        dout_if.data  = P_end_code;
        dout_if.valid = 1'b1;
        dout_if.last  = 1'b1;
        if (dout_if.ready) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk156m) begin
    if (i_srst) begin
      state_q     <= S_IDLE;
      pad_nz_q    <= 1'b0;
      end_ins_q   <= 1'b0;
      err_ovl_q   <= 1'b0;
`ifdef XA_BF_OUT_HDR_EN
      ft_q        <= '0;
      hdr_first_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pad_nz_q    <= pad_nz_d;
      end_ins_q   <= end_ins_d;
      err_ovl_q   <= err_ovl_d;
`ifdef XA_BF_OUT_HDR_EN
      ft_q        <= ft_d;
      hdr_first_q <= hdr_first_d;
`endif
    end
  end

  assign o_sp_end  = (state_q == S_DONE);
  assign o_busy    = (state_q != S_IDLE);
  assign o_err_ovl = err_ovl_q;

endmodule

// File: tb/tb_xa_bf_out_frm.sv
// Self-checking bench for xa_bf_out_frm (P_data_num=4); adapts to XA_BF_OUT_HDR_EN.
module tb_xa_bf_out_frm;
  import xa_bf_pkg::*;

  localparam logic [15:0] N_DATA = 16'd4;
  localparam logic [31:0] PAD_WORD = 32'h0000_0000;
  localparam logic [31:0] END_WORD = 32'hFFFF_FFFF;
`ifdef XA_BF_OUT_HDR_EN
  localparam int H = 1;
`else
  localparam int H = 0;
`endif

  logic        clk = 1'b0;
  logic        srst;
  logic        calc_start;
  logic [4:0]  frame_time;
  logic [19:0] pad_size;
  logic        end_ins;
  logic        sp_end, busy, err_ovl;

  always #5 clk = ~clk;

  xa_bf_out_frm_if in_if ();
  xa_bf_out_frm_if out_if ();

  xa_bf_out_frm #(.P_data_num(N_DATA)) dut (
    .i_clk156m    (clk),
    .i_srst       (srst),
    .i_calc_start (calc_start),
    .i_frame_time (frame_time),
    .i_pad_size   (pad_size),
    .i_end_ins    (end_ins),
    .din_if       (in_if),
    .dout_if      (out_if),
    .o_sp_end     (sp_end),
    .o_busy       (busy),
    .o_err_ovl    (err_ovl)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic [19:0] pad;
    logic        end_ins;
    logic [4:0]  ft;
    int          mode;      // 0: ready=1, 1: ready 1-0-0-1, 2: ready/valid gaps
    int          ovl_at;    // data beat count at which a second start is pulsed
    int          abort_at;  // data beat count at which reset is asserted
    int          exp_beats;
  } vec_t;

  beat_t sbq[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dval(input int id, input int k);
    return 32'hD000_0000 + 32'(id * 256 + k);
  endfunction

  function automatic logic rdy(input int mode, input int cyc);
    case (mode)
      1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
      2:       return (cyc % 5 != 0);
      default: return 1'b1;
    endcase
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_dout"}, out_if.data, 32'h0);
    chk({tag, "_valid"}, {31'h0, out_if.valid}, 32'h0);
    chk({tag, "_last"}, {31'h0, out_if.last}, 32'h0);
    chk({tag, "_din_ready"}, {31'h0, in_if.ready}, 32'h0);
    chk({tag, "_sp_end"}, {31'h0, sp_end}, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_err_ovl"}, {31'h0, err_ovl}, 32'h0);
  endtask

  task automatic run_frame(input int id, input vec_t v);
    int    total, beats, data_beats, din_idx, last_cyc, sp_cyc, sp_cnt;
    bit    done, ovl_done, stalled;
    logic [31:0] hold_d;
    logic        hold_l;
    beat_t e;
    beat_t words[$];

    if (H != 0) words.push_back('{{8'hA5, 3'b000, v.ft, N_DATA}, 1'b0});
    for (int k = 0; k < int'(N_DATA); k++) words.push_back('{dval(id, k), 1'b0});
    for (int k = 0; k < int'(v.pad); k++) words.push_back('{PAD_WORD, 1'b0});
    if (v.end_ins) words.push_back('{END_WORD, 1'b0});
    total = words.size();
    words[total-1].last = 1'b1;
    foreach (words[k]) sbq.push_back(words[k]);

    beats = 0; data_beats = 0; din_idx = 0; last_cyc = -10; sp_cyc = -10; sp_cnt = 0;
    done = 0; ovl_done = 0; stalled = 0; hold_d = '0; hold_l = 1'b0;

    @(negedge clk);
    calc_start = 1'b1;
    pad_size   = v.pad;
    end_ins    = v.end_ins;
    frame_time = v.ft;
    in_if.valid = 1'b0;

    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      calc_start = 1'b0;
      pad_size   = 20'hABCDE;
      end_ins    = ~v.end_ins;
      if (cyc >= 1) frame_time = ~v.ft;
      if (v.ovl_at != 0 && data_beats == v.ovl_at && !ovl_done) begin
        calc_start = 1'b1;
        pad_size   = 20'd7;
        ovl_done   = 1;
      end
      out_if.ready = rdy(v.mode, cyc);
      in_if.valid  = stalled ? 1'b1 : ((v.mode == 2) ? (cyc % 3 != 1) : 1'b1);
      in_if.data   = dval(id, din_idx);

      if (v.abort_at != 0 && data_beats == v.abort_at) begin
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        #1;
        check_idle_outputs("abort");
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          #1;
          chk("abort_no_sp_end", {31'h0, sp_end}, 32'h0);
        end
        sbq.delete();
        $display("[TB] frame %0d aborted after %0d data beats", id, data_beats);
        return;
      end

      #1;
      if (!done) chk("busy_in_frame", {31'h0, busy}, 32'h1);
      if (stalled) begin
        chk("stall_valid", {31'h0, out_if.valid}, 32'h1);
        chk("stall_data", out_if.data, hold_d);
        chk("stall_last", {31'h0, out_if.last}, {31'h0, hold_l});
      end
      if (out_if.valid && out_if.ready) begin
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat: got %h with no beat expected", out_if.data);
        end else begin
          tests--;
          e = sbq.pop_front();
          chk("beat_data", out_if.data, e.data);
          chk("beat_last", {31'h0, out_if.last}, {31'h0, e.last});
        end
        beats++;
        if (out_if.last) last_cyc = cyc;
      end
      if (in_if.valid && in_if.ready) begin
        data_beats++;
        din_idx++;
      end
      stalled = out_if.valid && !out_if.ready;
      hold_d  = out_if.data;
      hold_l  = out_if.last;
      if (sp_end) begin
        sp_cnt++;
        if (!done) sp_cyc = cyc;
        done = 1;
      end
      if (done && cyc >= sp_cyc + 2) break;
    end

    chk("frame_done", {31'h0, done}, 32'h1);
    chk("beat_count", beats, v.exp_beats);
    chk("sp_end_pulses", sp_cnt, 1);
    chk("sp_end_timing", sp_cyc, last_cyc + 1);
    chk("scoreboard_empty", sbq.size(), 0);
    chk("busy_after", {31'h0, busy}, 32'h0);
    if (v.ovl_at != 0) chk("err_ovl_sticky", {31'h0, err_ovl}, 32'h1);
    sbq.delete();
    $display("[TB] frame %0d pad=%0d end=%0d mode=%0d beats=%0d", id, v.pad, v.end_ins, v.mode, beats);
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{20'd0, 1'b0, 5'd3,  0, 0, 0, 4 + H};
    tbl[1] = '{20'd3, 1'b1, 5'd9,  0, 0, 0, 8 + H};
    tbl[2] = '{20'd3, 1'b0, 5'd17, 1, 0, 0, 7 + H};
    tbl[3] = '{20'd0, 1'b1, 5'd31, 2, 0, 0, 5 + H};
    tbl[4] = '{20'd0, 1'b0, 5'd1,  0, 2, 0, 4 + H};
    tbl[5] = '{20'd2, 1'b1, 5'd6,  0, 0, 2, 0};
    tbl[6] = '{20'd1, 1'b1, 5'd12, 1, 0, 0, 6 + H};

    srst         = 1'b1;
    calc_start   = 1'b0;
    frame_time   = '0;
    pad_size     = '0;
    end_ins      = 1'b0;
    in_if.data   = 32'h1234_5678;
    in_if.valid  = 1'b1;
    in_if.last   = 1'b0;
    out_if.ready = 1'b1;
    repeat (3) @(negedge clk);
    srst = 1'b0;
    #1;
    check_idle_outputs("reset");
    $display("[TB] reset state checked");

    foreach (tbl[i]) run_frame(i, tbl[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
